// File: rtl/hold_arbiter.sv
// Two-requester DMA arbiter that borrows the bus from an Intel 8088 using HOLD/HLDA.
// Requesters share the bus round-robin with a tenure limit, and the CPU always gets a gap after release.
module hold_arbiter #(
  parameter int MAX_TENURE = 16,
  parameter int CPU_GAP    = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] DREQ,
  input  logic       HLDA,
  output logic       HOLD,
  output logic [1:0] DACK,
  output logic       ERR
);

  localparam int TW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam int GW = (CPU_GAP > 1) ? $clog2(CPU_GAP) : 1;
  localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CPU_GAP - 1);

  typedef enum logic [2:0] {IDLE, REQ, GRANT, TURN, RELEASE, GAP} state_t;

  state_t        state, state_d;
  logic [TW-1:0] tenure, tenure_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          last, last_d;
  logic          hold_d, err_d;
  logic [1:0]    dack_d;
  logic          any_req, own_req, oth_req, win;
  logic [1:0]    win_dack;

  // While granted, last is the current owner, so the same pick also serves the TURN handoff.
  always_comb begin
    any_req  = |DREQ;
    own_req  = DREQ[last];
    oth_req  = DREQ[~last];
    win      = (DREQ == 2'b11) ? ~last : DREQ[1];
    win_dack = win ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d  = state;
    tenure_d = tenure;
    gap_d    = gap_cnt;
    last_d   = last;
    hold_d   = HOLD;
    dack_d   = DACK;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        hold_d = 1'b0;
        dack_d = 2'b00;
        if (any_req) begin
          state_d = REQ;
          hold_d  = 1'b1;
        end
      end
      REQ: begin
        if (HLDA) begin
          if (any_req) begin
            state_d  = GRANT;
            dack_d   = win_dack;
            last_d   = win;
            tenure_d = '0;
          end else begin
            state_d = RELEASE;
            hold_d  = 1'b0;
          end
        end
      end
      GRANT: begin
        if (!HLDA) begin
          state_d = RELEASE;
          hold_d  = 1'b0;
          dack_d  = 2'b00;
          err_d   = 1'b1;
        end else if (!own_req || (tenure == TEN_LAST && oth_req)) begin
          dack_d = 2'b00;
          if (oth_req) begin
            state_d = TURN;
          end else begin
            state_d = RELEASE;
            hold_d  = 1'b0;
          end
        end else if (tenure != TEN_LAST) begin
          tenure_d = tenure + 1'b1;
        end
      end
      TURN: begin
        if (!HLDA) begin
          state_d = RELEASE;
          hold_d  = 1'b0;
          dack_d  = 2'b00;
          err_d   = 1'b1;
        end else if (any_req) begin
          state_d  = GRANT;
          dack_d   = win_dack;
          last_d   = win;
          tenure_d = '0;
        end else begin
          state_d = RELEASE;
          hold_d  = 1'b0;
        end
      end
      RELEASE: begin
        hold_d = 1'b0;
        dack_d = 2'b00;
        if (!HLDA) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        // Requests arriving here simply wait; IDLE picks them up once the CPU has had its cycles.
        if (gap_cnt == GAP_LAST) state_d = IDLE;
        else                     gap_d   = gap_cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      tenure  <= '0;
      gap_cnt <= '0;
      last    <= 1'b1;
      HOLD    <= 1'b0;
      DACK    <= 2'b00;
      ERR     <= 1'b0;
    end else begin
      state   <= state_d;
      tenure  <= tenure_d;
      gap_cnt <= gap_d;
      last    <= last_d;
      HOLD    <= hold_d;
      DACK    <= dack_d;
      ERR     <= err_d;
    end
  end

endmodule

// File: tb/tb_hold_arbiter.sv
// Scoreboard bench for hold_arbiter: each scenario pushes expected {HOLD,DACK,ERR} as it drives
// inputs and pops/compares one cycle later.
module tb_hold_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] DREQ;
  logic       HLDA;
  logic       HOLD;
  logic [1:0] DACK;
  logic       ERR;

  int         checks = 0;
  int         fails  = 0;
  logic [3:0] sb[$];

  hold_arbiter #(.MAX_TENURE(16), .CPU_GAP(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA),
    .HOLD(HOLD), .DACK(DACK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    DREQ  = 2'b00;
    HLDA  = 1'b0;
    #2;
    RESET = 1'b1;
  endtask

  // Behaves like a cooperative CPU (HLDA follows HOLD) until the arbiter is back in IDLE.
  task automatic go_idle(input string tag);
    logic [3:0] e, got;
    DREQ = 2'b00;
    repeat (24) begin
      HLDA = HOLD;
      tick();
    end
    HLDA = 1'b0;
    sb.push_back(4'b0000);
    e = sb.pop_front();
    got = {HOLD, DACK, ERR};
    checks++;
    if (got !== e) begin
      fails++;
      $display("[TB] FAIL %s_idle: got hold/dack/err=%b want %b", tag, got, e);
    end
  endtask

  task automatic test_reset();
    logic [3:0] e, got;
    RESET = 1'b0;
    DREQ  = 2'b11;
    HLDA  = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(4'b0000);
      if (i > 0) tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL reset step%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    DREQ  = 2'b00;
    HLDA  = 1'b0;
    RESET = 1'b1;
  endtask

  task automatic test_single();
    logic [6:0] tbl [15] = '{
      7'b01_0_1_00_0, 7'b01_0_1_00_0, 7'b01_0_1_00_0,
      7'b01_1_1_01_0, 7'b01_1_1_01_0, 7'b01_1_1_01_0,
      7'b00_1_0_00_0, 7'b00_1_0_00_0,
      7'b01_0_0_00_0, 7'b01_0_0_00_0, 7'b01_0_0_00_0, 7'b01_0_0_00_0, 7'b01_0_0_00_0,
      7'b01_0_1_00_0, 7'b01_1_1_01_0
    };
    logic [3:0] e, got;
    do_reset();
    foreach (tbl[i]) begin
      DREQ = tbl[i][6:5];
      HLDA = tbl[i][4];
      sb.push_back(tbl[i][3:0]);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL single step%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("single");
  endtask

  task automatic test_round_robin();
    logic [3:0] e, got;
    logic [1:0] d;
    do_reset();
    DREQ = 2'b11;
    for (int i = -1; i < 51; i++) begin
      HLDA = (i >= 0);
      if (i < 0)              d = 2'b00;
      else if (i % 17 == 16)  d = 2'b00;
      else if ((i / 17) % 2 == 0) d = 2'b01;
      else                    d = 2'b10;
      sb.push_back({1'b1, d, 1'b0});
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL rr cycle%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("rr");
  endtask

  task automatic test_sole();
    logic [3:0] e, got;
    do_reset();
    DREQ = 2'b10;
    for (int i = -1; i < 40; i++) begin
      HLDA = (i >= 0);
      sb.push_back((i < 0) ? 4'b1000 : 4'b1100);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL sole cycle%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("sole");
  endtask

  task automatic test_withdraw();
    logic [6:0] tbl [4] = '{
      7'b01_0_1_00_0, 7'b00_0_1_00_0, 7'b00_1_0_00_0, 7'b00_0_0_00_0
    };
    logic [3:0] e, got;
    do_reset();
    foreach (tbl[i]) begin
      DREQ = tbl[i][6:5];
      HLDA = tbl[i][4];
      sb.push_back(tbl[i][3:0]);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL withdraw step%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("withdraw");
  endtask

  task automatic test_handoff();
    logic [6:0] tbl [5] = '{
      7'b01_0_1_00_0, 7'b01_1_1_01_0, 7'b10_1_1_00_0, 7'b10_1_1_10_0, 7'b10_1_1_10_0
    };
    logic [3:0] e, got;
    do_reset();
    foreach (tbl[i]) begin
      DREQ = tbl[i][6:5];
      HLDA = tbl[i][4];
      sb.push_back(tbl[i][3:0]);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL handoff step%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("handoff");
  endtask

  task automatic test_err();
    logic [6:0] tbl [6] = '{
      7'b01_0_1_00_0, 7'b01_1_1_01_0, 7'b01_1_1_01_0,
      7'b01_0_0_00_1, 7'b01_0_0_00_0, 7'b00_0_0_00_0
    };
    logic [3:0] e, got;
    do_reset();
    foreach (tbl[i]) begin
      DREQ = tbl[i][6:5];
      HLDA = tbl[i][4];
      sb.push_back(tbl[i][3:0]);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL err step%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("err");
  endtask

  task automatic test_reset_mid();
    logic [6:0] pre [3] = '{7'b10_0_1_00_0, 7'b10_1_1_10_0, 7'b10_1_1_10_0};
    logic [6:0] post [2] = '{7'b11_0_1_00_0, 7'b11_1_1_01_0};
    logic [3:0] e, got;
    do_reset();
    foreach (pre[i]) begin
      DREQ = pre[i][6:5];
      HLDA = pre[i][4];
      sb.push_back(pre[i][3:0]);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL rstmid pre%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    #2;
    RESET = 1'b0;
    HLDA  = 1'b0;
    DREQ  = 2'b00;
    sb.push_back(4'b0000);
    #1;
    e = sb.pop_front();
    got = {HOLD, DACK, ERR};
    checks++;
    if (got !== e) begin
      fails++;
      $display("[TB] FAIL rstmid async: got hold/dack/err=%b want %b", got, e);
    end
    #1;
    RESET = 1'b1;
    foreach (post[i]) begin
      DREQ = post[i][6:5];
      HLDA = post[i][4];
      sb.push_back(post[i][3:0]);
      tick();
      e = sb.pop_front();
      got = {HOLD, DACK, ERR};
      checks++;
      if (got !== e) begin
        fails++;
        $display("[TB] FAIL rstmid post%0d: got hold/dack/err=%b want %b", i, got, e);
      end
    end
    go_idle("rstmid");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_sole();
    test_withdraw();
    test_handoff();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hold_arbiter.md
HOLD_ARBITER -- requirements
Module: hold_arbiter

Interface
REQ-001 Parameter MAX_TENURE, default 16: maximum consecutive grant cycles while the other requester waits.
REQ-002 Parameter CPU_GAP, default 4: minimum cycles HOLD stays low after release before it is re-asserted.
REQ-003 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 DREQ  input  2  bus requests from DMA requesters 0/1; held high while the bus is wanted.
REQ-006 HLDA  input  1  hold acknowledge from the Intel8088.
REQ-007 HOLD  output  1  hold request to the Intel8088.
REQ-008 DACK  output  2  one-hot bus grant to a requester; all zero when no grant.
REQ-009 ERR  output  1  one-cycle pulse on protocol violation (HLDA lost during grant).

Function
REQ-010 All outputs shall be registered; states are IDLE, REQ, GRANT, TURN, RELEASE, GAP.
REQ-011 IDLE: HOLD=0, DACK=0; any DREQ bit high shall move to REQ with HOLD=1 from the next edge.
REQ-012 REQ: HOLD=1, DACK=0; on the edge HLDA is sampled 1, go to GRANT with DACK set in that same edge.
REQ-013 REQ with all DREQ low shall keep HOLD=1 until HLDA=1, then go to RELEASE without asserting DACK.
REQ-014 Grant selection shall be round-robin: a requester that is not the last granted wins when both request; a sole requester wins regardless of history.
REQ-015 GRANT: exactly one DACK bit high; tenure counter starts at 0 and increments each GRANT cycle.
REQ-016 GRANT, granted DREQ low and other DREQ high -> TURN; granted DREQ low and other low -> RELEASE.
REQ-017 GRANT, tenure = MAX_TENURE-1 and other DREQ high -> TURN (preemption) even if granted DREQ still high.
REQ-018 Tenure expiry with other DREQ low shall not preempt; grant continues and the counter saturates.
REQ-019 TURN: DACK=0, HOLD=1 for exactly one cycle; then GRANT to the other requester with tenure reset to 0.
REQ-020 RELEASE: HOLD=0, DACK=0; remain until HLDA sampled 0, then go to GAP.
REQ-021 GAP: HOLD=0 for CPU_GAP cycles (counter 0..CPU_GAP-1), then IDLE; DREQ during GAP is held off, not lost.
REQ-022 HLDA sampled 0 in GRANT or TURN shall clear DACK, pulse ERR for one cycle, and go to RELEASE.
REQ-023 DACK shall never be high while HOLD=0 or two DACK bits high simultaneously.
REQ-024 The last-granted pointer shall update on every entry to GRANT.

Reset
REQ-025 RESET low shall immediately force HOLD=0, DACK=0, ERR=0, state IDLE, counters 0, last-granted=1 (requester 0 wins the first tie).
REQ-026 Reset asserted mid-grant shall drop DACK and HOLD asynchronously; after release, the first DREQ follows REQ-011.

Verification
REQ-027 DREQ=01 from IDLE, HLDA rises 3 cycles after HOLD -> HOLD=1 next edge; DACK=01 on the edge HLDA is sampled; DREQ drop -> DACK=00, HOLD=0 the next edge.
REQ-028 DREQ=11 held continuously -> DACK=01 for 16 cycles, DACK=00 for 1 cycle, DACK=10 for 16 cycles, repeating; HOLD stays 1 throughout.
REQ-029 DREQ=10 alone held 40 cycles -> DACK=10 for all 40 cycles, no TURN.
REQ-030 Release, then DREQ=01 reasserted immediately -> HOLD low at least 4 cycles after HLDA falls before HOLD rises again.
REQ-031 HLDA forced to 0 during DACK=01 -> DACK=00 and ERR=1 for one cycle, then HOLD=0.
REQ-032 RESET low during DACK=10 -> HOLD=0, DACK=00 without waiting for a clock edge; next DREQ=11 tie goes to requester 0.
